cfg_scan_loader: RTL



---
 rtl/cfg_loader_pkg.sv | 30 +++
 rtl/scan_serializer.sv | 49 ++++
 rtl/cfg_scan_loader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared types and elaboration-time helpers for the column scan configuration loader.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLB_FETCH,
    CLB_SHIFT,
    CONN_FETCH,
    CONN_SHIFT,
    FINISH
  } state_t;

  function automatic int chain_len(input int tiles, input int bits_per_tile);
    return tiles * bits_per_tile;
  endfunction

  function automatic int words_per_chain(input int len, input int word_w);
    return (len + word_w - 1) / word_w;
  endfunction

  // Bits actually shifted from the final word of a chain.
  function automatic int last_word_bits(input int len, input int word_w);
    return ((len % word_w) == 0) ? word_w : (len % word_w);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_serializer.sv
// Shifts one configuration word out LSB-first, two clk cycles per bit
// (phase A: scan_clk low, phase B: scan_clk high).
module scan_serializer #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  input  logic [CNT_W-1:0]  num_bits,
  output logic              bit_out,
  output logic              scan_clk,
  output logic              word_done
);

  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  last_bit;
  logic              active;

  assign bit_out   = shreg[0];
  assign word_done = active && scan_clk && (bit_cnt == last_bit);

  // scan_clk doubles as the phase toggle; the register advances after phase B.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      last_bit <= '0;
      scan_clk <= 1'b0;
      active   <= 1'b0;
    end else if (load) begin
      shreg    <= data;
      bit_cnt  <= '0;
      last_bit <= num_bits - CNT_W'(1);
      scan_clk <= 1'b0;
      active   <= 1'b1;
    end else if (active) begin
      scan_clk <= ~scan_clk;
      if (scan_clk) begin
        shreg   <= {1'b0, shreg[WORD_W-1:1]};
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (bit_cnt == last_bit) active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cfg_scan_loader.sv
// Loads the CLB then connection scan chains of a tile column from a word stream.
// Optional readback of the chains' scan_out is enabled with CFG_READBACK_EN.
module cfg_scan_loader #(
  parameter int NUM_TILES          = 8,
  parameter int CLB_BITS_PER_TILE  = 32,
  parameter int CONN_BITS_PER_TILE = 64,
  parameter int WORD_W             = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              scan_clk,
  output logic              clb_scan_in,
  output logic              clb_scan_en,
  output logic              conn_scan_in,
  output logic              conn_scan_en,
  output logic              busy,
  output logic              done
`ifdef CFG_READBACK_EN
  ,
  input  logic              clb_scan_out,
  input  logic              conn_scan_out,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  import cfg_loader_pkg::*;

  localparam int CLB_LEN    = chain_len(NUM_TILES, CLB_BITS_PER_TILE);
  localparam int CONN_LEN   = chain_len(NUM_TILES, CONN_BITS_PER_TILE);
  localparam int BIT_CNT_W  = $clog2(max_int(CLB_LEN, CONN_LEN) + 1);
  localparam int WORD_CNT_W = $clog2(WORD_W + 1);

  state_t                state;
  state_t                state_next;
  logic [BIT_CNT_W-1:0]  bits_left;
  logic [WORD_CNT_W-1:0] word_bits;
  logic                  load;
  logic                  ser_bit;
  logic                  ser_clk;
  logic                  word_done;

  scan_serializer #(
    .WORD_W (WORD_W),
    .CNT_W  (WORD_CNT_W)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .data      (cfg_data),
    .num_bits  (word_bits),
    .bit_out   (ser_bit),
    .scan_clk  (ser_clk),
    .word_done (word_done)
  );

  // A word carries WORD_W bits unless fewer remain in the chain.
  always_comb begin
    word_bits = WORD_CNT_W'(WORD_W);
    if (32'(bits_left) < WORD_W) word_bits = WORD_CNT_W'(bits_left);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    cfg_ready  = 1'b0;
    case (state)
      IDLE:       if (start) state_next = CLB_FETCH;
      CLB_FETCH: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          load       = 1'b1;
          state_next = CLB_SHIFT;
        end
      end
      CLB_SHIFT:  if (word_done) state_next = (bits_left == '0) ? CONN_FETCH : CLB_FETCH;
      CONN_FETCH: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          load       = 1'b1;
          state_next = CONN_SHIFT;
        end
      end
      CONN_SHIFT: if (word_done) state_next = (bits_left == '0) ? FINISH : CONN_FETCH;
      FINISH:     state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Bits of the current chain not yet handed to the serializer.
  always_ff @(posedge clk) begin
    if (reset) begin
      bits_left <= '0;
    end else if (state == IDLE && start) begin
      bits_left <= BIT_CNT_W'(CLB_LEN);
    end else if (state == CLB_SHIFT && word_done && bits_left == '0) begin
      bits_left <= BIT_CNT_W'(CONN_LEN);
    end else if (load) begin
      bits_left <= bits_left - BIT_CNT_W'(word_bits);
    end
  end

  // Every scan-side output is re-registered so the tiles see glitch-free, aligned signals.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_clk     <= 1'b0;
      clb_scan_in  <= 1'b0;
      clb_scan_en  <= 1'b0;
      conn_scan_in <= 1'b0;
      conn_scan_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      scan_clk     <= ser_clk;
      clb_scan_in  <= (state == CLB_SHIFT) && ser_bit;
      conn_scan_in <= (state == CONN_SHIFT) && ser_bit;
      clb_scan_en  <= (state == CLB_FETCH) || (state == CLB_SHIFT);
      conn_scan_en <= (state == CONN_FETCH) || (state == CONN_SHIFT);
      busy         <= (state != IDLE);
      done         <= (state == FINISH);
    end
  end

`ifdef CFG_READBACK_EN
  logic [WORD_W-1:0]     rb_acc;
  logic [WORD_CNT_W-1:0] rb_idx;
  logic                  word_done_q;
  logic                  rb_bit;

  assign rb_bit = clb_scan_en ? clb_scan_out : conn_scan_out;

  // word_done_q lines up with the output-side phase B of a word's last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rb_acc      <= '0;
      rb_idx      <= '0;
      word_done_q <= 1'b0;
      rb_data     <= '0;
      rb_valid    <= 1'b0;
    end else begin
      rb_valid    <= 1'b0;
      word_done_q <= word_done;
      if (scan_clk) begin
        if (word_done_q) begin
          rb_data  <= rb_acc | (WORD_W'(rb_bit) << rb_idx);
          rb_valid <= 1'b1;
          rb_acc   <= '0;
          rb_idx   <= '0;
        end else begin
          rb_acc <= rb_acc | (WORD_W'(rb_bit) << rb_idx);
          rb_idx <= rb_idx + WORD_CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule
